packer_2b_to_8b: RTL and testbench
==================================

PACKER_2B_TO_8B -- requirements
Module: packer_2b_to_8b

Downstream stage of the 2-bit 2:1 mux: collects its 2-bit output symbols into bytes behind a valid/ready handshake.

Interface
REQ-001 The block SHALL have one parameter: PAD_VALUE, default 2'b00, the symbol written into unfilled slots of a flushed word.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 sym_in  input  2  data symbol, normally driven by the mux output.
REQ-006 sym_valid  input  1  sym_in holds a valid symbol this cycle.
REQ-007 sym_ready  output  1  block accepts a symbol this cycle.
REQ-008 flush  input  1  close the current partial word.
REQ-009 byte_out  output  8  packed byte.
REQ-010 byte_valid  output  1  byte_out holds a valid byte.
REQ-011 byte_ready  input  1  downstream accepts byte_out this cycle.
REQ-012 partial  output  1  qualifies byte_out; 1 = word closed by flush.
REQ-013 byte_count  output  8  count of bytes delivered.

Function
REQ-014 A symbol SHALL be accepted only on a clk edge where sym_valid=1 and sym_ready=1.
REQ-015 The internal slot counter (0..3) SHALL steer each accepted symbol into accumulator bits [2*slot+1:2*slot], so the first symbol lands in bits [1:0].
REQ-016 The FSM SHALL have two states: FILL (sym_ready=1) and HOLD (sym_ready=0).
REQ-017 A word SHALL complete on the accept with slot=3, or on flush=1 when slot>0 or a symbol is accepted in that same cycle.
REQ-018 On flush with a same-cycle accept, the accepted symbol SHALL be included before padding.
REQ-019 Unfilled slots of a flushed word SHALL be set to PAD_VALUE, and partial SHALL be 1 for that byte.
REQ-020 The output register SHALL be free when byte_valid=0, or when byte_valid=1 and byte_ready=1 in the same cycle.
REQ-021 On completion with the output register free, the word SHALL load at that edge: byte_valid=1 in the next cycle (latency 1), slot=0, FSM stays in FILL.
REQ-022 On completion with the output register busy, the FSM SHALL go to HOLD, keep the word, and set slot=0.
REQ-023 In HOLD, on the first cycle the output register is free, the held word SHALL load and the FSM SHALL return to FILL.
REQ-024 While byte_valid=1 and byte_ready=0, byte_out and partial SHALL remain stable.
REQ-025 byte_valid SHALL clear after a handshake unless a new word loads at the same edge; back-to-back bytes therefore need no bubble.
REQ-026 flush SHALL be ignored in HOLD, and in FILL when slot=0 with no accept in that cycle.
REQ-027 byte_count SHALL increment by 1 on each edge where byte_valid=1 and byte_ready=1, wrapping from 255 to 0.
REQ-028 byte_ready SHALL be ignored while byte_valid=0.

Reset
REQ-029 While reset=1 at a clk edge, the block SHALL force: FSM to FILL, slot=0, accumulator=0, byte_out=0, byte_valid=0, partial=0, byte_count=0.
REQ-030 sym_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-031 Reset mid-operation SHALL discard any partial word and any held or pending byte, with no byte emitted.

Verification
REQ-032 Reset; then send 01,10,11,00 on consecutive cycles with byte_ready=1 -> byte_out=0x39, partial=0, byte_valid high exactly one cycle, byte_count=1.
REQ-033 Hold byte_ready=0; send eight 2'b11 symbols -> byte_out=0xFF held, FSM enters HOLD, sym_ready=0; then set byte_ready=1 -> two 0xFF bytes on consecutive cycles, sym_ready=1, byte_count=2.
REQ-034 Send 10,01 then flush alone -> byte_out=0x06, partial=1. Then flush with slot=0 -> no byte emitted.
REQ-035 Send 01,01, then 11 with flush in the same cycle -> byte_out=0x35, partial=1, slot=0 afterwards.
REQ-036 Send 3 symbols, pulse reset for 1 cycle, then send 11,00,00,00 -> only one byte emitted, 0x03, partial=0, byte_count=1.
REQ-037 Deliver 256 bytes with byte_ready=1 -> byte_count reads 255 after the 255th byte and 0 after the 256th.

Source files
------------

// File: rtl/packer_2b_to_8b.sv
// Packs 2-bit symbols (first symbol in bits [1:0]) into bytes; flush closes a partial word with padding.
// Latency: a completed word shows byte_valid one cycle after the completing edge when the output register is free.
// Backpressure: one held word behind a stalled output register; sym_ready drops while a word is held.
module packer_2b_to_8b #(
    parameter logic [1:0] PAD_VALUE = 2'b00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic       flush,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       partial,
    output logic [7:0] byte_count
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] slot;
    logic [7:0] acc;
    logic       held_partial;

    logic       accept;
    logic       out_free;
    logic       complete;
    logic       word_partial;
    logic [2:0] filled;
    logic [7:0] word;

    assign sym_ready    = (state == FILL) && !reset;
    assign accept       = sym_valid && sym_ready;
    assign out_free     = !byte_valid || byte_ready;
    assign filled       = {1'b0, slot} + {2'b00, accept};
    assign complete     = (accept && slot == 2'd3) ||
                          (flush && state == FILL && filled != 3'd0);
    // A word that reached four symbols is full even if flush arrived with its last symbol.
    assign word_partial = (filled != 3'd4);

    always_comb begin
        word = acc;
        if (accept) begin
            word[{slot, 1'b0} +: 2] = sym_in;
        end
        if (flush) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) >= filled) begin
                    word[2*i +: 2] = PAD_VALUE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            slot         <= 2'd0;
            acc          <= 8'd0;
            held_partial <= 1'b0;
            byte_out     <= 8'd0;
            byte_valid   <= 1'b0;
            partial      <= 1'b0;
            byte_count   <= 8'd0;
        end else begin
            if (byte_valid && byte_ready) begin
                byte_count <= byte_count + 8'd1;
                byte_valid <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (complete) begin
                        slot <= 2'd0;
                        if (out_free) begin
                            byte_out   <= word;
                            partial    <= word_partial;
                            byte_valid <= 1'b1;
                            acc        <= 8'd0;
                        end else begin
                            // Accumulator doubles as the hold buffer: no symbols arrive in HOLD.
                            acc          <= word;
                            held_partial <= word_partial;
                            state        <= HOLD;
                        end
                    end else if (accept) begin
                        acc[{slot, 1'b0} +: 2] <= sym_in;
                        slot                   <= slot + 2'd1;
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        byte_out   <= acc;
                        partial    <= held_partial;
                        byte_valid <= 1'b1;
                        acc        <= 8'd0;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (byte_valid && !byte_ready) |=> (byte_valid && $stable(byte_out) && $stable(partial)));

    a_hold_no_ready: assert property (@(posedge clk) disable iff (reset)
        (state == HOLD) |-> (!sym_ready && slot == 2'd0));

endmodule

// File: tb/tb_packer_2b_to_8b.sv
// Randomized and directed bench for packer_2b_to_8b against a queue-based transaction model.
module tb_packer_2b_to_8b;

    localparam logic [1:0] PAD = 2'b00;

    logic       clk_probador;
    logic       reset;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       flush;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       partial;
    logic [7:0] byte_count;

    int n_checks;
    int n_fail;

    // Model: symbols of the open word, and up to two finished words {partial, byte}
    // (the one on the output plus one waiting behind it).
    logic [1:0] cur[$];
    logic [8:0] out_q[$];
    logic [7:0] m_count;

    packer_2b_to_8b #(.PAD_VALUE(PAD)) dut (
        .clk        (clk_probador),
        .reset      (reset),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .flush      (flush),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .partial    (partial),
        .byte_count (byte_count)
    );

    initial clk_probador = 1'b0;
    always #5 clk_probador = ~clk_probador;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic sv, input logic [1:0] s,
                              input logic fl, input logic br);
        logic       rdy;
        logic       acc;
        logic       cmp;
        logic [7:0] w;
        if (r) begin
            cur.delete();
            out_q.delete();
            m_count = 8'd0;
        end else begin
            rdy = (out_q.size() < 2);
            acc = sv && rdy;
            if (acc) cur.push_back(s);
            cmp = (acc && cur.size() == 4) || (fl && rdy && cur.size() > 0);
            if (out_q.size() > 0 && br) begin
                out_q.delete(0);
                m_count = m_count + 8'd1;
            end
            if (cmp) begin
                w = 8'd0;
                for (int i = 0; i < 4; i++) begin
                    w[2*i +: 2] = (i < cur.size()) ? cur[i] : PAD;
                end
                out_q.push_back({(cur.size() < 4), w});
                cur.delete();
            end
        end
    endtask

    // Drive one cycle at the negedge, advance the model, check at the next negedge.
    task automatic cyc(input logic r, input logic sv, input logic [1:0] s,
                       input logic fl, input logic br);
        reset      = r;
        sym_valid  = sv;
        sym_in     = s;
        flush      = fl;
        byte_ready = br;
        model_step(r, sv, s, fl, br);
        @(posedge clk_probador);
        @(negedge clk_probador);
        chk("sym_ready", 32'(sym_ready), 32'(!r && out_q.size() < 2));
        chk("byte_valid", 32'(byte_valid), 32'(out_q.size() > 0));
        if (out_q.size() > 0) begin
            chk("byte_out", 32'(byte_out), 32'(out_q[0][7:0]));
            chk("partial", 32'(partial), 32'(out_q[0][8]));
        end
        chk("byte_count", 32'(byte_count), 32'(m_count));
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] seq[4];
        n_checks   = 0;
        n_fail     = 0;
        m_count    = 8'd0;
        reset      = 1'b1;
        sym_in     = 2'b00;
        sym_valid  = 1'b0;
        flush      = 1'b0;
        byte_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_byte_out", 32'(byte_out), 32'h00);
        chk("rst_partial", 32'(partial), 32'h0);
        chk("rst_sym_ready", 32'(sym_ready), 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("ready_after_rst", 32'(sym_ready), 32'h1);

        // 01,10,11,00 -> 0x39, one-cycle valid, one byte counted
        seq = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, seq[i], 1'b0, 1'b1);
        chk("b39_valid", 32'(byte_valid), 32'h1);
        chk("b39_byte", 32'(byte_out), 32'h39);
        chk("b39_partial", 32'(partial), 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("b39_valid_drop", 32'(byte_valid), 32'h0);
        chk("b39_count", 32'(byte_count), 32'd1);

        // Backpressure: eight 11s with byte_ready=0 fills output and hold
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("hold_ready", 32'(sym_ready), 32'h0);
        chk("hold_byte", 32'(byte_out), 32'hFF);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("hold_b2b_valid", 32'(byte_valid), 32'h1);
        chk("hold_b2b_byte", 32'(byte_out), 32'hFF);
        chk("hold_ready_back", 32'(sym_ready), 32'h1);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("hold_count", 32'(byte_count), 32'd2);
        chk("hold_drained", 32'(byte_valid), 32'h0);

        // 10,01 then lone flush -> 0x06 partial; flush at slot 0 emits nothing
        do_reset();
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        chk("fl_byte", 32'(byte_out), 32'h06);
        chk("fl_partial", 32'(partial), 32'h1);
        cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        chk("fl_empty_valid", 32'(byte_valid), 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("fl_empty_count", 32'(byte_count), 32'd1);

        // 01,01 then 11 with flush -> 0x35 partial; slot restarts at 0
        do_reset();
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
        chk("flacc_byte", 32'(byte_out), 32'h35);
        chk("flacc_partial", 32'(partial), 32'h1);
        seq = '{2'b01, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, seq[i], 1'b0, 1'b1);
        chk("flacc_slot0", 32'(byte_out), 32'h01);

        // Reset mid-word discards the partial symbols
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        seq = '{2'b11, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, seq[i], 1'b0, 1'b1);
        chk("mid_rst_byte", 32'(byte_out), 32'h03);
        chk("mid_rst_partial", 32'(partial), 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("mid_rst_count", 32'(byte_count), 32'd1);

        // 256 bytes: counter wraps
        do_reset();
        for (int i = 1; i <= 1024; i++) begin
            cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
            if (i == 1021) chk("cnt_255", 32'(byte_count), 32'd255);
        end
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        chk("cnt_wrap", 32'(byte_count), 32'd0);

        // Random traffic with backpressure, flushes and occasional reset
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
